// File: rtl/shiftreg_pkg.sv
// ---------------------------------------------------------------------------
// shiftreg_pkg
// Shared definitions for the TMIIa shift-register transmitter and the
// readback receiver: FSM state encoding, default word / counter widths and
// the load-strobe length helper.
// ---------------------------------------------------------------------------
package shiftreg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } sr_state_e;

   // Word length of the TMIIa configuration register and the bit-counter
   // width the transmitter and receiver agree on.
   localparam int SR_DATA_WIDTH = 170;
   localparam int SR_CNT_WIDTH  = 8;

   // Number of clk cycles sr_load stays high: LOAD_WIDTH full sr_clk periods.
   function automatic int load_cycles(input int load_width, input int half_period);
      return 2 * load_width * half_period;
   endfunction

endpackage

// File: rtl/shiftreg_sclk_gen.sv
// ---------------------------------------------------------------------------
// shiftreg_sclk_gen
// Divides clk down to the shift clock. sr_clk toggles every div_q+1 clk
// cycles while enable is high and is forced low (counter cleared) otherwise,
// so the first rising edge always lands div_q+1 cycles after enable rises.
//
// Ports
//   clk, rst   : system clock, async active-high reset
//   enable     : run the divider (high for the whole SHIFT phase)
//   div_q      : half-period minus 1, in clk cycles
//   sr_clk     : registered shift clock, idles low
//   rise_stb   : high in the cycle whose closing edge raises sr_clk
//   fall_stb   : high in the cycle whose closing edge lowers sr_clk
// ---------------------------------------------------------------------------
module shiftreg_sclk_gen #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] div_q,
   output logic                 sr_clk,
   output logic                 rise_stb,
   output logic                 fall_stb
);

   logic [DIV_WIDTH-1:0] hc;
   logic                 wrap;

   assign wrap     = enable && (hc == div_q);
   // Strobes announce the toggle on the coming edge, so the caller can move
   // data in the same edge that sr_clk falls.
   assign rise_stb = wrap && !sr_clk;
   assign fall_stb = wrap &&  sr_clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc     <= '0;
         sr_clk <= 1'b0;
      end else if (!enable) begin
         hc     <= '0;
         sr_clk <= 1'b0;
      end else if (wrap) begin
         hc     <= '0;
         sr_clk <= ~sr_clk;
      end else begin
         hc     <= hc + 1'b1;
      end
   end

endmodule

// File: rtl/shiftreg_send_data.sv
// ---------------------------------------------------------------------------
// shiftreg_send_data
// Serial writer for the TMIIa configuration shift register. On an accepted
// start it captures din/div, clocks DATA_WIDTH bits out on sr_data (changing
// only on sr_clk falling edges), then strobes sr_load for LOAD_WIDTH sr_clk
// periods and pulses done. rx_start fires with the accepted start so the
// readback receiver can sample the displaced contents in step.
//
// Ports
//   clk, rst  : system clock, async active-high reset
//   start     : request a transfer (only looked at in IDLE)
//   din       : parallel word, captured on accepted start
//   div       : sr_clk half-period minus 1, captured on accepted start
//   sr_clk    : shift clock, idles low
//   sr_data   : serial data, 0 outside SHIFT
//   sr_load   : latch strobe
//   rx_start  : one-cycle pulse with the accepted start
//   busy      : high from accepted start through DONE
//   done      : one-cycle completion pulse
// ---------------------------------------------------------------------------
module shiftreg_send_data
   import shiftreg_pkg::*;
#(
   parameter int DATA_WIDTH      = SR_DATA_WIDTH,
   parameter int CNT_WIDTH       = SR_CNT_WIDTH,
   parameter int SHIFT_DIRECTION = 1,
   parameter int DIV_WIDTH       = 8,
   parameter int LOAD_WIDTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [DIV_WIDTH-1:0]  div,
   output logic                  sr_clk,
   output logic                  sr_data,
   output logic                  sr_load,
   output logic                  rx_start,
   output logic                  busy,
   output logic                  done
);

   localparam int BC_W = CNT_WIDTH + 1;
   // Wide enough for 2*LOAD_WIDTH*2^DIV_WIDTH - 1.
   localparam int LT_W = DIV_WIDTH + $clog2(LOAD_WIDTH + 1) + 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

   sr_state_e             state;
   logic [DATA_WIDTH-1:0] shadow;
   logic [DATA_WIDTH-1:0] shadow_nxt;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [BC_W-1:0]       bc;
   logic [LT_W-1:0]       lt;
   logic [LT_W-1:0]       lt_last;
   logic                  sclk_en;
   logic                  sclk_rise_unused;
   logic                  sclk_fall;

   // Bit presented on sr_data for a given shadow content.
   function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
      return (SHIFT_DIRECTION != 0) ? v[DATA_WIDTH-1] : v[0];
   endfunction

   generate
      if (SHIFT_DIRECTION != 0) begin : g_msb_first
         assign shadow_nxt = {shadow[DATA_WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign shadow_nxt = {1'b0, shadow[DATA_WIDTH-1:1]};
      end
   endgenerate

   assign sclk_en = (state == ST_SHIFT);
   assign lt_last = LT_W'(load_cycles(LOAD_WIDTH, int'(div_q) + 1) - 1);

   shiftreg_sclk_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_sclk (
      .clk      (clk),
      .rst      (rst),
      .enable   (sclk_en),
      .div_q    (div_q),
      .sr_clk   (sr_clk),
      .rise_stb (sclk_rise_unused),
      .fall_stb (sclk_fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         shadow   <= '0;
         div_q    <= '0;
         bc       <= '0;
         lt       <= '0;
         sr_data  <= 1'b0;
         sr_load  <= 1'b0;
         rx_start <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         rx_start <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  shadow   <= din;
                  div_q    <= div;
                  bc       <= '0;
                  lt       <= '0;
                  // First bit is on the wire a full half-period before the
                  // first sr_clk rise.
                  sr_data  <= out_bit(din);
                  rx_start <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Data moves only with the falling sr_clk edge, giving a
               // full half-period of setup and hold around each rise.
               if (sclk_fall) begin
                  shadow <= shadow_nxt;
                  bc     <= bc + 1'b1;
                  if (bc == BC_LAST) begin
                     sr_data <= 1'b0;
                     sr_load <= 1'b1;
                     lt      <= '0;
                     state   <= ST_LOAD;
                  end else begin
                     sr_data <= out_bit(shadow_nxt);
                  end
               end
            end
            ST_LOAD: begin
               if (lt == lt_last) begin
                  sr_load <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  lt <= lt + 1'b1;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shiftreg_send_data.sv
// ---------------------------------------------------------------------------
// tb_shiftreg_send_data
// Directed bench for shiftreg_send_data. Two instances share clk/rst/din/div:
// dut_m shifts MSB first, dut_l LSB first. Expected serial bits are queued
// when a transfer is launched and popped on every observed sr_clk rise.
// ---------------------------------------------------------------------------
module tb_shiftreg_send_data;

   localparam int N  = 170;
   localparam int DW = 8;
   localparam int LW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_m = 1'b0;
   logic          start_l = 1'b0;
   logic [N-1:0]  din = '0;
   logic [DW-1:0] div = '0;

   logic m_clk, m_data, m_load, m_rx, m_busy, m_done;
   logic l_clk, l_data, l_load, l_rx, l_busy, l_done;

   logic sel = 1'b0;
   wire  o_clk  = sel ? l_clk  : m_clk;
   wire  o_data = sel ? l_data : m_data;
   wire  o_load = sel ? l_load : m_load;
   wire  o_rx   = sel ? l_rx   : m_rx;
   wire  o_busy = sel ? l_busy : m_busy;
   wire  o_done = sel ? l_done : m_done;

   int   nvec = 0;
   int   nerr = 0;
   logic q_bits[$];
   logic [N-1:0] pat;

   always #5 clk = ~clk;

   shiftreg_send_data #(
      .DATA_WIDTH(N), .CNT_WIDTH(8), .SHIFT_DIRECTION(1), .DIV_WIDTH(DW), .LOAD_WIDTH(LW)
   ) dut_m (
      .clk(clk), .rst(rst), .start(start_m), .din(din), .div(div),
      .sr_clk(m_clk), .sr_data(m_data), .sr_load(m_load),
      .rx_start(m_rx), .busy(m_busy), .done(m_done)
   );

   shiftreg_send_data #(
      .DATA_WIDTH(N), .CNT_WIDTH(8), .SHIFT_DIRECTION(0), .DIV_WIDTH(DW), .LOAD_WIDTH(LW)
   ) dut_l (
      .clk(clk), .rst(rst), .start(start_l), .din(din), .div(div),
      .sr_clk(l_clk), .sr_data(l_data), .sr_load(l_load),
      .rx_start(l_rx), .busy(l_busy), .done(l_done)
   );

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk_b({tag, " sr_clk"},   o_clk,  1'b0);
      chk_b({tag, " sr_data"},  o_data, 1'b0);
      chk_b({tag, " sr_load"},  o_load, 1'b0);
      chk_b({tag, " rx_start"}, o_rx,   1'b0);
      chk_b({tag, " busy"},     o_busy, 1'b0);
      chk_b({tag, " done"},     o_done, 1'b0);
   endtask

   // mode 0: plain transfer; 1: retrigger with other din/div at bit 20;
   // 2: reset at bit 50 and abandon the transfer.
   task automatic run_xfer(input string nm, input bit lsb, input logic [N-1:0] d,
                           input logic [DW-1:0] dv, input int mode);
      int   h, l, t2nh, tot;
      int   rises, falls, falls_bad, load_cyc, first_load, dones, done_at;
      int   rx_cyc, busy_bad, data_bad;
      logic prev, exp_bit;
      h = int'(dv) + 1;
      l = 2 * LW * h;
      t2nh = 2 * N * h;
      tot = t2nh + l;
      rises = 0; falls = 0; falls_bad = 0; load_cyc = 0; first_load = -1;
      dones = 0; done_at = -1; rx_cyc = 0; busy_bad = 0; data_bad = 0;
      prev = 1'b0;
      q_bits.delete();
      for (int i = 0; i < N; i++) q_bits.push_back(lsb ? d[i] : d[N-1-i]);
      sel = lsb;
      @(negedge clk);
      din = d;
      div = dv;
      if (lsb) start_l = 1'b1; else start_m = 1'b1;
      @(negedge clk);
      start_l = 1'b0;
      start_m = 1'b0;
      for (int c = 0; c <= tot + 1; c++) begin
         if (c == 0) begin
            chk_b({nm, " busy@T0"},     o_busy, 1'b1);
            chk_b({nm, " rx_start@T0"}, o_rx,   1'b1);
            chk_b({nm, " sr_clk@T0"},   o_clk,  1'b0);
            chk_b({nm, " sr_data@T0"},  o_data, q_bits[0]);
         end
         if (o_clk && !prev) begin
            chk_i({nm, " rise_time"}, c, h * (2 * rises + 1));
            if (q_bits.size() == 0) begin
               chk_i({nm, " extra_rise"}, rises, N - 1);
            end else begin
               exp_bit = q_bits.pop_front();
               chk_b({nm, " bit"}, o_data, exp_bit);
            end
            rises++;
            if (mode == 1 && rises == 20) begin
               din = ~d;
               div = dv + 8'd3;
               start_m = 1'b1;
            end
            if (mode == 2 && rises == 50) begin
               rst = 1'b1;
               #1;
               chk_b({nm, " rst sr_clk"},  o_clk,  1'b0);
               chk_b({nm, " rst sr_data"}, o_data, 1'b0);
               chk_b({nm, " rst busy"},    o_busy, 1'b0);
               chk_b({nm, " rst sr_load"}, o_load, 1'b0);
               chk_i({nm, " load_before_rst"}, load_cyc, 0);
               @(negedge clk);
               chk_b({nm, " rst hold sr_load"}, o_load, 1'b0);
               rst = 1'b0;
               @(negedge clk);
               chk_idle({nm, " after_rst"});
               return;
            end
         end
         if (!o_clk && prev) begin
            if (c != 2 * h * (falls + 1)) falls_bad++;
            falls++;
         end
         if (o_load) begin
            load_cyc++;
            if (first_load < 0) first_load = c;
         end
         if (o_done) begin
            dones++;
            done_at = c;
         end
         if (c > 0 && o_rx) rx_cyc++;
         if (o_busy !== (c <= tot)) busy_bad++;
         if (c >= t2nh && o_data !== 1'b0) data_bad++;
         prev = o_clk;
         @(negedge clk);
         start_m = 1'b0;
      end
      chk_i({nm, " rises"},        rises,         N);
      chk_i({nm, " falls"},        falls,         N);
      chk_i({nm, " fall_timing"},  falls_bad,     0);
      chk_i({nm, " queue_left"},   q_bits.size(), 0);
      chk_i({nm, " load_width"},   load_cyc,      l);
      chk_i({nm, " load_start"},   first_load,    t2nh);
      chk_i({nm, " done_count"},   dones,         1);
      chk_i({nm, " done_time"},    done_at,       tot);
      chk_i({nm, " rx_extra"},     rx_cyc,        0);
      chk_i({nm, " busy_window"},  busy_bad,      0);
      chk_i({nm, " data_idle"},    data_bad,      0);
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(negedge clk);
      chk_idle("por_held");
      rst = 1'b0;
      @(negedge clk);
      chk_idle("por_released");

      // Transfer 1: alternating pattern, MSB first, div=0
      for (int i = 0; i < N; i++) pat[i] = (i % 2 == 1);
      run_xfer("xfer1", 1'b0, pat, 8'd0, 0);

      // Reset while idle
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_idle("idle_rst_held");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("idle_rst_released");

      // Transfer 2: LSB first, din=1
      pat = '0;
      pat[0] = 1'b1;
      run_xfer("xfer2_lsb", 1'b1, pat, 8'd0, 0);

      // Transfer 3: random word, div=3
      for (int i = 0; i < N; i++) pat[i] = 1'($urandom_range(0, 1));
      run_xfer("xfer3_div3", 1'b0, pat, 8'd3, 0);

      // Start/din/div changes mid-transfer are ignored
      for (int i = 0; i < N; i++) pat[i] = 1'($urandom_range(0, 1));
      run_xfer("xfer_retrig", 1'b0, pat, 8'd1, 1);

      // Reset during SHIFT, then a clean full transfer
      for (int i = 0; i < N; i++) pat[i] = 1'($urandom_range(0, 1));
      run_xfer("xfer_abort", 1'b0, pat, 8'd0, 2);
      for (int i = 0; i < N; i++) pat[i] = 1'($urandom_range(0, 1));
      run_xfer("xfer_after_abort", 1'b0, pat, 8'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/shiftreg_send_data.md
Name: shiftreg_send_data

Overview:
- Serial transmitter that writes a DATA_WIDTH-bit configuration word into the TMIIa shift register.
- Captures a parallel word on start and generates the shift clock (sr_clk) by dividing clk.
- Drives sr_data one bit per sr_clk period, then asserts the load strobe (sr_load).
- Emits rx_start so the readback receiver captures the displaced old contents in step with the shift.

Parameters:
DATA_WIDTH, 170, bits per transfer
CNT_WIDTH, 8, bit counter is CNT_WIDTH+1 bits; DATA_WIDTH <= 2^(CNT_WIDTH+1)-1
SHIFT_DIRECTION, 1, 1: MSB shifted out first; 0: LSB first
DIV_WIDTH, 8, width of the div input
LOAD_WIDTH, 2, sr_load high time in sr_clk periods (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin transfer; sampled only in IDLE
din  input  DATA_WIDTH  word to shift in; captured on accepted start
div  input  DIV_WIDTH  sr_clk half-period minus 1, in clk cycles; captured on accepted start
sr_clk  output  1  shift clock to the SR; idles low
sr_data  output  1  serial data to the SR
sr_load  output  1  latch strobe to the SR
rx_start  output  1  one-cycle pulse to the readback receiver
busy  output  1  high from accepted start through DONE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, state IDLE, shadow/counters 0.
- Reset mid-transfer aborts immediately; there is no partial-load strobe.
- States are IDLE, SHIFT, LOAD, DONE.
- Let H = div+1 and N = DATA_WIDTH.
- IDLE:
  - start=1 at edge T0: latch din into shadow and div into div_q.
  - bit counter bc=0, half-period counter hc=0.
  - Go to SHIFT; busy=1 and rx_start=1 for the T0 cycle only.
- SHIFT:
  - sr_data = shadow[N-1] if SHIFT_DIRECTION=1, else shadow[0]. It is valid from T0.
  - hc counts 0..div_q. At hc==div_q, hc wraps to 0 and sr_clk toggles.
  - sr_clk rises at T0+H*(2k+1), for k=0..N-1.
  - Each falling toggle shifts shadow (left if SHIFT_DIRECTION=1, right otherwise; 0 filled) and increments bc.
  - Data therefore changes only on the sr_clk falling edge; setup/hold is H clk cycles each side.
  - The fall that makes bc==N moves to LOAD at T0+2NH, with sr_clk=0.
- LOAD:
  - sr_load=1 for exactly 2*LOAD_WIDTH*H clk cycles.
  - sr_clk stays 0 and sr_data is 0.
  - Then go to DONE.
- DONE:
  - done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Total latency from accepted start to the done pulse: 2NH + 2*LOAD_WIDTH*H cycles.
- sr_data is 0 outside SHIFT.
- start in SHIFT, LOAD or DONE is ignored. din/div changes during a transfer have no effect.
- start held high: a new transfer is accepted on the first IDLE cycle after DONE (one idle cycle between transfers).
- div=0 gives sr_clk = clk/2. div=all-ones is legal.
- All outputs are registered; sr_clk is generated without glitches.

Decomposition:
- Shared package shiftreg_pkg holds:
  - state encodings (IDLE, SHIFT, LOAD, DONE);
  - default DATA_WIDTH (170) and CNT_WIDTH (8), shared with the readback receiver.
- One sub-module, shiftreg_sclk_gen:
  - holds the half-period counter and the sr_clk register;
  - inputs: clk, rst, enable, div_q;
  - outputs: sr_clk, rise_stb, fall_stb.
- The top level holds the FSM, shadow register, bit counter and the load timer.

Test Plan:
1. Assert rst mid-simulation while idle -> every output reads 0 while rst is high and one cycle after release; busy=0.
2. Transfer 1, all defaults:
   - Stimulus: div=0, din = 170-bit alternating 1010... (MSB=1), start pulse at T0.
   - Bench samples sr_data on each sr_clk rise -> exactly 170 rises at T0+1,3,...,339.
   - Collected stream equals din MSB-first.
   - sr_load high during cycles T0+340..343; done pulse at T0+344; rx_start only at T0.
3. Transfer 2: SHIFT_DIRECTION=0, din=1, div=0 -> first sampled bit 1, remaining 169 bits 0.
4. Transfer 3: div=3, din random -> sr_clk period 8 cycles with 4 high and 4 low, 170 rises, sr_load width 16 cycles, done at T0+1376.
5. Accept start with din=A. At bit 20, pulse start with din=B and change div -> transfer completes with stream A and the original timing. Exactly one done pulse.
6. Assert rst during SHIFT at bit 50 -> sr_clk/sr_data/busy go 0 immediately and sr_load never asserts. After release, a new start performs a full correct 170-bit transfer.
